// File: rtl/dcache_flush_walker_if.sv
// Handshake bundle of the dcache flush walker: flush controller request/ack,
// tag/status array port and writeback-unit request port.
interface dcache_flush_walker_if #(
  parameter int NUM_SETS  = 256,
  parameter int NUM_WAYS  = 8,
  parameter int TAG_WIDTH = 44
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                          flush_i;
  logic                          flush_ack_o;
  logic                          busy_o;
  logic                          arr_req_o;
  logic                          arr_we_o;
  logic [IDX_W-1:0]              arr_idx_o;
  logic [NUM_WAYS-1:0]           arr_wmask_o;
  logic                          arr_gnt_i;
  logic [NUM_WAYS-1:0]           arr_valid_i;
  logic [NUM_WAYS-1:0]           arr_dirty_i;
  logic [NUM_WAYS*TAG_WIDTH-1:0] arr_tag_i;
  logic                          wb_valid_o;
  logic                          wb_ready_i;
  logic [TAG_WIDTH-1:0]          wb_tag_o;
  logic [IDX_W-1:0]              wb_idx_o;
  logic [WAY_W-1:0]              wb_way_o;
  logic                          wb_idle_i;

  // The walker is the master: it issues array and writeback requests.
  modport master (
    input  flush_i, arr_gnt_i, arr_valid_i, arr_dirty_i, arr_tag_i, wb_ready_i, wb_idle_i,
    output flush_ack_o, busy_o, arr_req_o, arr_we_o, arr_idx_o, arr_wmask_o,
           wb_valid_o, wb_tag_o, wb_idx_o, wb_way_o
  );

  modport slave (
    output flush_i, arr_gnt_i, arr_valid_i, arr_dirty_i, arr_tag_i, wb_ready_i, wb_idle_i,
    input  flush_ack_o, busy_o, arr_req_o, arr_we_o, arr_idx_o, arr_wmask_o,
           wb_valid_o, wb_tag_o, wb_idx_o, wb_way_o
  );
endinterface

// File: rtl/dcache_flush_walker.sv
// Walks every set of the write-back dcache on a flush, writes back dirty lines,
// cleans (or, with DCACHE_FLUSH_INVALIDATE_EN defined, invalidates) them and acks.
module dcache_flush_walker #(
  parameter int NUM_SETS  = 256,
  parameter int NUM_WAYS  = 8,
  parameter int TAG_WIDTH = 44
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dcache_flush_walker_if.master bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WB, S_UPDATE, S_DRAIN, S_ACK
  } state_e;

  state_e                              state_q, state_d;
  logic   [IDX_W-1:0]                  idx_q;
  logic                                armed_q;
  logic   [NUM_WAYS-1:0]               dirty_q;
  logic   [NUM_WAYS-1:0]               upd_mask_q;
  logic   [NUM_WAYS-1:0][TAG_WIDTH-1:0] tags_q;

  logic [NUM_WAYS-1:0] cap_dirty;
  logic [NUM_WAYS-1:0] cap_mask;
  logic [NUM_WAYS-1:0] sel_onehot;
  logic [WAY_W-1:0]    sel_way;
  logic                last_set;
  logic                wb_last;

  assign cap_dirty = bus.arr_valid_i & bus.arr_dirty_i;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
  assign cap_mask  = bus.arr_valid_i;
`else
  assign cap_mask  = cap_dirty;
`endif
  assign last_set  = (idx_q == LAST_IDX);

  // Lowest-numbered pending dirty way is written back first.
  // NOTE: sel_way gets its default before the loop, so every path assigns it and no latch is inferred.
  always_comb begin
    sel_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (dirty_q[w]) sel_way = WAY_W'(w);
    end
  end

  assign sel_onehot = NUM_WAYS'(1) << sel_way;
  assign wb_last    = ((dirty_q & ~sel_onehot) == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (bus.flush_i && armed_q) state_d = S_READ;
      S_READ:    if (bus.arr_gnt_i) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (cap_dirty != '0)     state_d = S_WB;
        else if (cap_mask != '0) state_d = S_UPDATE;
        else                     state_d = last_set ? S_DRAIN : S_READ;
      end
      S_WB:      if (bus.wb_ready_i && wb_last) state_d = S_UPDATE;
      S_UPDATE:  if (bus.arr_gnt_i) state_d = last_set ? S_DRAIN : S_READ;
      S_DRAIN:   if (bus.wb_idle_i) state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Walk index, re-arm flag and the captured per-set status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      armed_q    <= 1'b1;
      dirty_q    <= '0;
      upd_mask_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        if (!bus.flush_i) begin
          armed_q <= 1'b1;
        end else if (armed_q) begin
          armed_q <= 1'b0;
          idx_q   <= '0;
        end
      end
      if (state_q == S_CAPTURE) begin
        dirty_q    <= cap_dirty;
        upd_mask_q <= cap_mask;
      end
      if (state_q == S_WB && bus.wb_ready_i) dirty_q <= dirty_q & ~sel_onehot;
      if (state_d == S_READ && (state_q == S_CAPTURE || state_q == S_UPDATE))
        idx_q <= idx_q + IDX_W'(1);
    end
  end

  // NOTE: tag payload has no reset; it is only observed in WB, which is always entered through CAPTURE.
  always_ff @(posedge clk_i) begin
    if (state_q == S_CAPTURE) tags_q <= bus.arr_tag_i;
  end

  always_comb begin
    bus.flush_ack_o = 1'b0;
    bus.busy_o      = (state_q != S_IDLE);
    bus.arr_req_o   = 1'b0;
    bus.arr_we_o    = 1'b0;
    bus.arr_idx_o   = '0;
    bus.arr_wmask_o = '0;
    bus.wb_valid_o  = 1'b0;
    bus.wb_tag_o    = '0;
    bus.wb_idx_o    = '0;
    bus.wb_way_o    = '0;
    unique case (state_q)
      S_READ: begin
        bus.arr_req_o = 1'b1;
        bus.arr_idx_o = idx_q;
      end
      S_UPDATE: begin
        bus.arr_req_o   = 1'b1;
        bus.arr_we_o    = 1'b1;
        bus.arr_idx_o   = idx_q;
        bus.arr_wmask_o = upd_mask_q;
      end
      S_WB: begin
        bus.wb_valid_o = 1'b1;
        bus.wb_tag_o   = tags_q[sel_way];
        bus.wb_idx_o   = idx_q;
        bus.wb_way_o   = sel_way;
      end
      S_ACK:   bus.flush_ack_o = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dcache_flush_walker.sv
// Self-checking bench for dcache_flush_walker: array/writeback responder plus a
// set-level model of which lines get written back and which status bits get cleared.
`timescale 1ns/1ps
module tb_dcache_flush_walker;
  localparam int NS = 4;
  localparam int NW = 8;
  localparam int TW = 44;
  localparam int IW = $clog2(NS);
  localparam int WW = $clog2(NW);
  localparam int OUTW = 4 + IW + NW + 1 + TW + IW + WW;
`ifdef DCACHE_FLUSH_INVALIDATE_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  dcache_flush_walker_if #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW)) bus ();

  dcache_flush_walker #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_WIDTH(TW)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  typedef struct packed { logic [IW-1:0] idx; logic [WW-1:0] way; logic [TW-1:0] tag; } wb_rec_t;
  typedef struct packed { logic [IW-1:0] idx; logic [NW-1:0] mask; } upd_rec_t;

  int checks = 0;
  int errors = 0;

  // Cache contents as seen by the array, and the walk's expected effect on it.
  logic [NW-1:0] mem_valid [NS];
  logic [NW-1:0] mem_dirty [NS];
  logic [TW-1:0] mem_tag   [NS][NW];
  logic [NW-1:0] exp_valid_fin [NS];
  logic [NW-1:0] exp_dirty_fin [NS];
  wb_rec_t  exp_wb[$];
  upd_rec_t exp_upd[$];

  wb_rec_t  got_wb[$];
  int       got_len[$];
  upd_rec_t got_upd[$];
  int       got_rd[$];
  int       ack_at[$];
  int stall_cycles, stab_err, idle_err, we_cycles;

  int cyc = 0;
  int t0 = 0;
  int rd_stall_pct = 0, wb_stall_pct = 0;
  int rd_stall_set = -1, rd_stall_left = 0, wb_hold_left = 0, idle_low_until = -1;

  bit            rd_pend;
  logic [IW-1:0] rd_pend_idx;
  bit            prev_stall;
  wb_rec_t       prev_wb;
  int            cur_len;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Responder: drives array/writeback inputs on the falling edge and logs what the walker did.
  always @(negedge clk_i) begin
    wb_rec_t cur;
    bit gnt, rdy;
    if (!rst_ni) begin
      rd_pend = 0; prev_stall = 0; cur_len = 0;
      bus.arr_gnt_i = 0; bus.wb_ready_i = 0; bus.wb_idle_i = 1;
      bus.arr_valid_i = '0; bus.arr_dirty_i = '0; bus.arr_tag_i = '0;
    end else begin
      if (rd_pend) begin
        bus.arr_valid_i = mem_valid[rd_pend_idx];
        bus.arr_dirty_i = mem_dirty[rd_pend_idx];
        for (int w = 0; w < NW; w++) bus.arr_tag_i[w*TW +: TW] = mem_tag[rd_pend_idx][w];
        rd_pend = 0;
      end else begin
        bus.arr_valid_i = NW'($urandom);
        bus.arr_dirty_i = NW'($urandom);
        for (int w = 0; w < NW; w++) bus.arr_tag_i[w*TW +: TW] = TW'({$urandom, $urandom});
      end

      gnt = ($urandom_range(99) >= rd_stall_pct);
      if (bus.arr_req_o && !bus.arr_we_o && int'(bus.arr_idx_o) == rd_stall_set && rd_stall_left > 0) begin
        gnt = 0;
        rd_stall_left--;
      end
      bus.arr_gnt_i = gnt;
      if (bus.arr_we_o) we_cycles++;
      if (bus.arr_req_o && !gnt) stall_cycles++;
      if (bus.arr_req_o && gnt) begin
        if (bus.arr_we_o) begin
          got_upd.push_back('{idx: bus.arr_idx_o, mask: bus.arr_wmask_o});
          mem_dirty[bus.arr_idx_o] &= ~bus.arr_wmask_o;
          if (INV) mem_valid[bus.arr_idx_o] &= ~bus.arr_wmask_o;
        end else begin
          rd_pend = 1;
          rd_pend_idx = bus.arr_idx_o;
          got_rd.push_back(int'(bus.arr_idx_o));
        end
      end

      cur = '{idx: bus.wb_idx_o, way: bus.wb_way_o, tag: bus.wb_tag_o};
      if (prev_stall && (!bus.wb_valid_o || cur !== prev_wb)) stab_err++;
      rdy = ($urandom_range(99) >= wb_stall_pct);
      if (bus.wb_valid_o && wb_hold_left > 0) begin
        rdy = 0;
        wb_hold_left--;
      end
      bus.wb_ready_i = rdy;
      if (bus.wb_valid_o) begin
        cur_len++;
        if (rdy) begin
          got_wb.push_back(cur);
          got_len.push_back(cur_len);
          cur_len = 0;
        end else begin
          stall_cycles++;
        end
      end
      prev_stall = bus.wb_valid_o && !rdy;
      prev_wb = cur;

      bus.wb_idle_i = ((cyc - t0) > idle_low_until);

      if (!bus.arr_req_o && (bus.arr_we_o || bus.arr_idx_o != '0 || bus.arr_wmask_o != '0)) idle_err++;
      if (!bus.wb_valid_o && (bus.wb_tag_o != '0 || bus.wb_idx_o != '0 || bus.wb_way_o != '0)) idle_err++;
      if ((bus.arr_req_o || bus.wb_valid_o || bus.flush_ack_o) && !bus.busy_o) idle_err++;
      if (bus.arr_req_o && bus.wb_valid_o) idle_err++;
      if (bus.flush_ack_o) ack_at.push_back(cyc - t0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [OUTW-1:0] out_vec();
    return {bus.flush_ack_o, bus.busy_o, bus.arr_req_o, bus.arr_we_o, bus.arr_idx_o, bus.arr_wmask_o,
            bus.wb_valid_o, bus.wb_tag_o, bus.wb_idx_o, bus.wb_way_o};
  endfunction

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic load_cache(input int valid_pct, input int dirty_pct);
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        mem_valid[s][w] = ($urandom_range(99) < valid_pct);
        mem_dirty[s][w] = ($urandom_range(99) < dirty_pct);
        mem_tag[s][w]   = TW'({$urandom, $urandom});
      end
    end
  endtask

  // Expected effect of one walk, derived set by set from the cache contents.
  task automatic build_expected();
    logic [NW-1:0] mask;
    exp_wb.delete();
    exp_upd.delete();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++)
        if (mem_valid[s][w] && mem_dirty[s][w]) exp_wb.push_back('{idx: IW'(s), way: WW'(w), tag: mem_tag[s][w]});
      mask = INV ? mem_valid[s] : (mem_valid[s] & mem_dirty[s]);
      if (mask != '0) exp_upd.push_back('{idx: IW'(s), mask: mask});
      exp_valid_fin[s] = INV ? '0 : mem_valid[s];
      exp_dirty_fin[s] = mem_dirty[s] & ~mem_valid[s];
    end
  endtask

  task automatic clear_logs();
    got_wb.delete(); got_len.delete(); got_upd.delete(); got_rd.delete(); ack_at.delete();
    stall_cycles = 0; stab_err = 0; idle_err = 0; we_cycles = 0;
  endtask

  // Controller behaviour: request until ack, then keep the registered level for hold_after cycles.
  task automatic run_walk(input int hold_after, output bit done, output int lat);
    int n0;
    n0 = ack_at.size();
    done = 0;
    tick();
    bus.flush_i = 1;
    t0 = cyc;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      if (ack_at.size() > n0) done = 1;
    end
    lat = done ? ack_at[n0] : -1;
    repeat (hold_after + 1) tick();
    bus.flush_i = 0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (out_vec() !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", out_vec()); end
    rst_ni = 1;
    repeat (3) tick();
    checks++;
    if (out_vec() !== '0) begin errors++; $display("FAIL idle_outputs: got %h expected 0", out_vec()); end
  endtask

  task automatic test_empty_cache();
    bit done; int lat;
    load_cache(0, 50);
    build_expected();
    clear_logs();
    run_walk(1, done, lat);
    checks++;
    if (!done) begin errors++; $display("FAIL empty_ack: no ack within cycle budget"); end
    checks++;
    if (lat !== 2*NS + 2) begin errors++; $display("FAIL empty_latency: got %0d expected %0d", lat, 2*NS + 2); end
    repeat (4) tick();
    checks++;
    if (ack_at.size() !== 1) begin errors++; $display("FAIL empty_ack_count: got %0d expected 1", ack_at.size()); end
    checks++;
    if (got_wb.size() !== 0) begin errors++; $display("FAIL empty_wb: got %0d writebacks expected 0", got_wb.size()); end
    checks++;
    if (we_cycles !== 0) begin errors++; $display("FAIL empty_we: got %0d write cycles expected 0", we_cycles); end
    checks++;
    if (idle_err !== 0) begin errors++; $display("FAIL empty_idle_outputs: got %0d violations expected 0", idle_err); end
    checks++;
    if (got_rd.size() !== NS) begin errors++; $display("FAIL empty_reads: got %0d reads expected %0d", got_rd.size(), NS); end
    for (int i = 0; i < got_rd.size() && i < NS; i++) begin
      checks++;
      if (got_rd[i] !== i) begin errors++; $display("FAIL empty_read_order[%0d]: got %0d expected %0d", i, got_rd[i], i); end
    end
  endtask

  task automatic test_dirty_set();
    bit done; int lat;
    load_cache(0, 0);
    mem_valid[2] = 8'b0010_0010;
    mem_dirty[2] = 8'b0010_0010;
    build_expected();
    clear_logs();
    wb_hold_left = 3;
    run_walk(1, done, lat);
    checks++;
    if (got_wb.size() !== 2) begin errors++; $display("FAIL dirty_wb_count: got %0d expected 2", got_wb.size()); end
    for (int i = 0; i < got_wb.size() && i < exp_wb.size(); i++) begin
      checks++;
      if (got_wb[i] !== exp_wb[i]) begin errors++; $display("FAIL dirty_wb[%0d]: got %h expected %h", i, got_wb[i], exp_wb[i]); end
    end
    if (got_len.size() == 2) begin
      checks++;
      if (got_len[0] !== 4) begin errors++; $display("FAIL dirty_hold_way1: got %0d cycles expected 4", got_len[0]); end
      checks++;
      if (got_len[1] !== 1) begin errors++; $display("FAIL dirty_hold_way5: got %0d cycles expected 1", got_len[1]); end
    end
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL dirty_stable: got %0d payload changes expected 0", stab_err); end
    checks++;
    if (got_upd.size() !== 1 || got_upd[0] !== upd_rec_t'({2'd2, 8'b0010_0010})) begin
      errors++; $display("FAIL dirty_wmask: got %0d updates first %h expected 1 update %h", got_upd.size(),
                         (got_upd.size() > 0) ? got_upd[0] : upd_rec_t'(0), upd_rec_t'({2'd2, 8'b0010_0010}));
    end
    checks++;
    if (lat !== 2*NS + 2 + 2 + 1 + 3) begin errors++; $display("FAIL dirty_latency: got %0d expected %0d", lat, 2*NS + 8); end
    checks++;
    if ({mem_valid[2], mem_dirty[2]} !== {exp_valid_fin[2], exp_dirty_fin[2]}) begin
      errors++; $display("FAIL dirty_final_status: got %b/%b expected %b/%b", mem_valid[2], mem_dirty[2], exp_valid_fin[2], exp_dirty_fin[2]);
    end
  endtask

  task automatic test_invalidate();
    bit done; int lat;
    load_cache(0, 0);
    mem_valid[0] = 8'b0000_1001;
    mem_dirty[0] = 8'b0100_1000;
    build_expected();
    clear_logs();
    run_walk(1, done, lat);
    checks++;
    if (got_wb.size() !== 1 || got_wb[0] !== exp_wb[0]) begin
      errors++; $display("FAIL inv_wb: got %0d writebacks first %h expected 1 writeback %h", got_wb.size(),
                         (got_wb.size() > 0) ? got_wb[0] : wb_rec_t'(0), exp_wb[0]);
    end
    checks++;
    if (got_upd.size() !== 1 || got_upd[0] !== exp_upd[0]) begin
      errors++; $display("FAIL inv_wmask: got %0d updates first %h expected 1 update %h", got_upd.size(),
                         (got_upd.size() > 0) ? got_upd[0] : upd_rec_t'(0), exp_upd[0]);
    end
    checks++;
    if (lat !== 2*NS + 4) begin errors++; $display("FAIL inv_latency: got %0d expected %0d", lat, 2*NS + 4); end
    checks++;
    if ({mem_valid[0], mem_dirty[0]} !== {exp_valid_fin[0], exp_dirty_fin[0]}) begin
      errors++; $display("FAIL inv_final_status: got %b/%b expected %b/%b", mem_valid[0], mem_dirty[0], exp_valid_fin[0], exp_dirty_fin[0]);
    end
  endtask

  task automatic test_stalls();
    bit done; int lat;
    load_cache(0, 0);
    build_expected();
    clear_logs();
    rd_stall_set = 1;
    rd_stall_left = 5;
    idle_low_until = (2*NS + 1 + 5) + 6;
    run_walk(1, done, lat);
    repeat (4) tick();
    idle_low_until = -1;
    rd_stall_set = -1;
    checks++;
    if (lat !== 2*NS + 2 + 5 + 7) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, 2*NS + 14); end
    checks++;
    if (rd_stall_left !== 0 || stall_cycles !== 5) begin
      errors++; $display("FAIL stall_read_held: got %0d stall cycles (%0d left) expected 5 (0 left)", stall_cycles, rd_stall_left);
    end
    checks++;
    if (ack_at.size() !== 1) begin errors++; $display("FAIL stall_ack_count: got %0d expected 1", ack_at.size()); end
    checks++;
    if (got_rd.size() !== NS) begin errors++; $display("FAIL stall_reads: got %0d expected %0d", got_rd.size(), NS); end
  endtask

  task automatic test_rearm();
    bit done; int lat;
    load_cache(0, 0);
    build_expected();
    clear_logs();
    run_walk(1, done, lat);
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rearm_no_restart: busy %b expected 0", bus.busy_o); end
    clear_logs();
    run_walk(3, done, lat);
    checks++;
    if (!done || lat !== 2*NS + 2) begin errors++; $display("FAIL rearm_second_walk: latency %0d expected %0d", lat, 2*NS + 2); end
    checks++;
    if (got_rd.size() !== NS) begin errors++; $display("FAIL rearm_reads: got %0d expected %0d", got_rd.size(), NS); end
    repeat (3) tick();
    checks++;
    if (bus.busy_o !== 1'b0 || ack_at.size() !== 1) begin
      errors++; $display("FAIL rearm_long_hold: busy %b acks %0d expected 0 and 1", bus.busy_o, ack_at.size());
    end
  endtask

  task automatic test_reset_mid_walk();
    bit found, done; int lat;
    load_cache(0, 0);
    mem_valid[3] = 8'b0001_0100;
    mem_dirty[3] = 8'b0001_0100;
    build_expected();
    clear_logs();
    wb_hold_left = 100;
    tick();
    bus.flush_i = 1;
    t0 = cyc;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (bus.wb_valid_o && bus.wb_idx_o == IW'(3)) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_reach_wb: writeback of set 3 not seen within budget"); end
    rst_ni = 0;
    bus.flush_i = 0;
    #1;
    checks++;
    if (out_vec() !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0", out_vec()); end
    repeat (2) tick();
    rst_ni = 1;
    wb_hold_left = 0;
    repeat (5) tick();
    checks++;
    if (ack_at.size() !== 0 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_no_ack: acks %0d busy %b expected 0 and 0", ack_at.size(), bus.busy_o);
    end
    clear_logs();
    run_walk(1, done, lat);
    checks++;
    if (got_rd.size() !== NS || got_rd[0] !== 0) begin
      errors++; $display("FAIL rst_restart_set0: reads %0d first %0d expected %0d from 0", got_rd.size(),
                         (got_rd.size() > 0) ? got_rd[0] : -1, NS);
    end
    checks++;
    if (got_wb.size() !== exp_wb.size() || !done) begin
      errors++; $display("FAIL rst_restart_wb: got %0d writebacks expected %0d (ack seen %0d)", got_wb.size(), exp_wb.size(), done);
    end
  endtask

  task automatic test_random();
    bit done; int lat, exp_lat;
    for (int iter = 0; iter < 8; iter++) begin
      load_cache(50, 50);
      build_expected();
      clear_logs();
      rd_stall_pct = $urandom_range(40);
      wb_stall_pct = $urandom_range(50);
      run_walk(1, done, lat);
      rd_stall_pct = 0;
      wb_stall_pct = 0;
      exp_lat = 2*NS + 2 + exp_wb.size() + exp_upd.size() + stall_cycles;
      checks++;
      if (!done || lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", iter, lat, exp_lat); end
      checks++;
      if (got_wb.size() !== exp_wb.size()) begin
        errors++; $display("FAIL rand%0d_wb_count: got %0d expected %0d", iter, got_wb.size(), exp_wb.size());
      end
      for (int i = 0; i < got_wb.size() && i < exp_wb.size(); i++) begin
        checks++;
        if (got_wb[i] !== exp_wb[i]) begin errors++; $display("FAIL rand%0d_wb[%0d]: got %h expected %h", iter, i, got_wb[i], exp_wb[i]); end
      end
      checks++;
      if (got_upd.size() !== exp_upd.size()) begin
        errors++; $display("FAIL rand%0d_upd_count: got %0d expected %0d", iter, got_upd.size(), exp_upd.size());
      end
      for (int i = 0; i < got_upd.size() && i < exp_upd.size(); i++) begin
        checks++;
        if (got_upd[i] !== exp_upd[i]) begin errors++; $display("FAIL rand%0d_upd[%0d]: got %h expected %h", iter, i, got_upd[i], exp_upd[i]); end
      end
      for (int s = 0; s < NS; s++) begin
        checks++;
        if ({mem_valid[s], mem_dirty[s]} !== {exp_valid_fin[s], exp_dirty_fin[s]}) begin
          errors++; $display("FAIL rand%0d_final[%0d]: got %b/%b expected %b/%b", iter, s, mem_valid[s], mem_dirty[s], exp_valid_fin[s], exp_dirty_fin[s]);
        end
      end
      checks++;
      if (stab_err !== 0 || idle_err !== 0) begin
        errors++; $display("FAIL rand%0d_protocol: got %0d stability and %0d idle-output violations expected 0", iter, stab_err, idle_err);
      end
      checks++;
      if (ack_at.size() !== 1) begin errors++; $display("FAIL rand%0d_ack_count: got %0d expected 1", iter, ack_at.size()); end
    end
  endtask

  initial begin
    bus.flush_i = 0;
    test_reset();
    test_empty_cache();
    test_dirty_set();
    test_invalidate();
    test_stalls();
    test_rearm();
    test_reset_mid_walk();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
